// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencer and the ALU it drives.
// Opcodes, FSM state codes, instruction layout and opcode classification.
package alu_seq_ctrl_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int REG_NUM    = 8;
  localparam int REG_IDX_W  = 3;
  localparam int INSTR_W    = 16;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SR  = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_SL  = 4'b1010;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  // LDI reuses {rs1, rs2, rsvd} as its 9-bit immediate.
  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rsvd;
  } instr_t;

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_LDI,
    CLS_ALU,
    CLS_ILL
  } op_cls_e;

  function automatic op_cls_e op_classify(input logic [3:0] op);
    case (op)
      OP_NOP:  return CLS_NOP;
      OP_LDI:  return CLS_LDI;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SR, OP_SRA, OP_SL: return CLS_ALU;
      default: return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake, ALU bus, status and debug port of the sequencer.
// slave = sequencer side, master = instruction source / ALU / debug side.
interface alu_seq_ctrl_if
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
);

  logic [INSTR_W-1:0]   instr_i;
  logic                 instr_valid_i;
  logic                 instr_ready_o;
  logic [3:0]           alu_opcode_o;
  logic [DATA_W-1:0]    alu_a_o;
  logic [DATA_W-1:0]    alu_b_o;
  logic [DATA_W-1:0]    alu_out_i;
  logic                 alu_zero_i;
  logic                 done_o;
  logic                 illegal_o;
  logic                 zero_flag_o;
  logic [REG_IDX_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0]    dbg_data_o;

  modport slave (
    input  instr_i, instr_valid_i, alu_out_i, alu_zero_i, dbg_addr_i,
    output instr_ready_o, alu_opcode_o, alu_a_o, alu_b_o,
           done_o, illegal_o, zero_flag_o, dbg_data_o
  );

  modport master (
    output instr_i, instr_valid_i, alu_out_i, alu_zero_i, dbg_addr_i,
    input  instr_ready_o, alu_opcode_o, alu_a_o, alu_b_o,
           done_o, illegal_o, zero_flag_o, dbg_data_o
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// Register file with r0 hard-wired to zero: two async read ports, a debug read
// port, one write port committed on the rising edge, async clear; no backpressure.
module alu_seq_regfile
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int NREG   = REG_NUM,
  parameter int IDX_W  = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [IDX_W-1:0]  i_rd1_addr,
  output logic [DATA_W-1:0] o_rd1_data,
  input  logic [IDX_W-1:0]  i_rd2_addr,
  output logic [DATA_W-1:0] o_rd2_data,
  input  logic [IDX_W-1:0]  i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_regs [NREG];

  // r_regs[0] is only ever cleared, so r0 reads zero with no read-side muxing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd1_data = r_regs[i_rd1_addr];
  assign o_rd2_data = r_regs[i_rd2_addr];
  assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Four-state sequencer feeding an external combinational ALU; done 3 cycles after accept.
// Accepts one instruction per 4 cycles; instr_ready_o is high only in IDLE.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int NREG   = REG_NUM
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  alu_seq_ctrl_if.slave bus
);

  logic [1:0]        r_state;
  instr_t            r_instr;
  op_cls_e           r_cls;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_res;
  logic              r_res_zero;
  logic              r_zero_flag;

  logic              w_accept;
  logic              w_alu_drive;
  logic              w_wr_en;
  logic [8:0]        w_imm9;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;

  assign w_accept = (r_state == S_IDLE) && bus.instr_valid_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      r_cls       <= CLS_NOP;
      r_opa       <= '0;
      r_opb       <= '0;
      r_res       <= '0;
      r_res_zero  <= 1'b0;
      r_zero_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_instr <= bus.instr_i;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_opa   <= w_rs1_data;
          r_opb   <= w_rs2_data;
          r_cls   <= op_classify(r_instr.op);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_res      <= bus.alu_out_i;
          r_res_zero <= bus.alu_zero_i;
          r_state    <= S_WB;
        end
        S_WB: begin
          if (r_cls == CLS_ALU) r_zero_flag <= r_res_zero;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ALU bus is live through EXEC and held through WB so the result stays stable.
  assign w_alu_drive = ((r_state == S_EXEC) || (r_state == S_WB)) && (r_cls == CLS_ALU);

  assign w_imm9     = {r_instr.rs1, r_instr.rs2, r_instr.rsvd};
  assign w_imm_sext = {{(DATA_W-9){w_imm9[8]}}, w_imm9};
  assign w_wr_en    = (r_state == S_WB) && ((r_cls == CLS_ALU) || (r_cls == CLS_LDI));
  assign w_wr_data  = (r_cls == CLS_LDI) ? w_imm_sext : r_res;

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .i_clk      (clk_i),
    .i_rst_n    (rst_n_i),
    .i_rd1_addr (r_instr.rs1),
    .o_rd1_data (w_rs1_data),
    .i_rd2_addr (r_instr.rs2),
    .o_rd2_data (w_rs2_data),
    .i_dbg_addr (bus.dbg_addr_i),
    .o_dbg_data (bus.dbg_data_o),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (r_instr.rd),
    .i_wr_data  (w_wr_data)
  );

  assign bus.instr_ready_o = (r_state == S_IDLE);
  assign bus.alu_opcode_o  = w_alu_drive ? r_instr.op : OP_NOP;
  assign bus.alu_a_o       = w_alu_drive ? r_opa : '0;
  assign bus.alu_b_o       = w_alu_drive ? r_opb : '0;
  assign bus.done_o        = (r_state == S_WB);
  assign bus.illegal_o     = (r_state == S_WB) && (r_cls == CLS_ILL);
  assign bus.zero_flag_o   = r_zero_flag;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 16-bit ALU on the bus.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] exec_op, exec_a, exec_b;

  alu_seq_ctrl_if #(.DATA_W(16)) bus ();

  alu_seq_ctrl #(.DATA_W(16), .NREG(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // External ALU; non-ALU cycles see junk so ignored results would show up.
  always_comb begin
    case (bus.alu_opcode_o)
      OP_ADD:  bus.alu_out_i = bus.alu_a_o + bus.alu_b_o;
      OP_SUB:  bus.alu_out_i = bus.alu_a_o - bus.alu_b_o;
      OP_AND:  bus.alu_out_i = bus.alu_a_o & bus.alu_b_o;
      OP_OR:   bus.alu_out_i = bus.alu_a_o | bus.alu_b_o;
      OP_XOR:  bus.alu_out_i = bus.alu_a_o ^ bus.alu_b_o;
      OP_SR:   bus.alu_out_i = bus.alu_a_o >> bus.alu_b_o[2:0];
      OP_SRA:  bus.alu_out_i = 16'($signed(bus.alu_a_o) >>> bus.alu_b_o[2:0]);
      OP_SL:   bus.alu_out_i = bus.alu_a_o << bus.alu_b_o[2:0];
      default: bus.alu_out_i = 16'hDEAD;
    endcase
    bus.alu_zero_i = (bus.alu_out_i == 16'h0000);
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {OP_LDI, rd, imm};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    bus.dbg_addr_i = a;
    #1;
    check_val(tag, bus.dbg_data_o, exp);
  endtask

  // Issues one instruction, keeps valid high with junk until WB, checks latency and illegal.
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic exp_ill);
    int w;
    int lat;
    w = 0;
    @(negedge clk);
    while (bus.instr_ready_o !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_val({tag, "/rdy"}, bus.instr_ready_o, 1);
    bus.instr_i       = ins;
    bus.instr_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_i = 16'($urandom);
    lat = 1;
    while (bus.done_o !== 1'b1 && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) begin
        exec_op = {12'h0, bus.alu_opcode_o};
        exec_a  = bus.alu_a_o;
        exec_b  = bus.alu_b_o;
      end
    end
    bus.instr_valid_i = 1'b0;
    check_val({tag, "/lat"}, lat, 3);
    check_val({tag, "/ill"}, bus.illegal_o, exp_ill);
    @(posedge clk);
    #1;
    check_val({tag, "/pulse"}, {bus.done_o, bus.illegal_o}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    logic [15:0] q [4];
    int idx;
    int n_done;
    int acc [4];

    bus.instr_i       = '0;
    bus.instr_valid_i = 1'b0;
    bus.dbg_addr_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst/ready", bus.instr_ready_o, 1);
    check_val("rst/done_ill", {bus.done_o, bus.illegal_o}, 0);
    check_val("rst/zero", bus.zero_flag_o, 0);
    check_val("rst/alu_bus", {bus.alu_opcode_o, bus.alu_a_o, bus.alu_b_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("ldi_r1", ldi(3'd1, 9'd5), 1'b0);
    check_reg("r1=5", 3'd1, 16'h0005);
    run_instr("ldi_r2", ldi(3'd2, 9'd3), 1'b0);
    run_instr("add_r3", enc(OP_ADD, 3'd3, 3'd1, 3'd2), 1'b0);
    check_val("add/exec_op", exec_op, 32'(OP_ADD));
    check_val("add/exec_ab", {exec_a, exec_b}, {16'h0005, 16'h0003});
    check_reg("r3=8", 3'd3, 16'h0008);
    check_val("add/zero", bus.zero_flag_o, 0);
    check_val("idle/alu_a", bus.alu_a_o, 0);

    run_instr("sub_r4", enc(OP_SUB, 3'd4, 3'd1, 3'd1), 1'b0);
    check_reg("r4=0", 3'd4, 16'h0000);
    check_val("sub/zero", bus.zero_flag_o, 1);
    run_instr("ldi_r5", ldi(3'd5, 9'h1FF), 1'b0);
    check_reg("r5=ffff", 3'd5, 16'hFFFF);
    check_val("ldi/zero_kept", bus.zero_flag_o, 1);

    run_instr("ldi_r6", ldi(3'd6, 9'h100), 1'b0);
    check_reg("r6=ff00", 3'd6, 16'hFF00);
    run_instr("ldi_r7", ldi(3'd7, 9'd4), 1'b0);
    run_instr("sra", enc(OP_SRA, 3'd1, 3'd6, 3'd7), 1'b0);
    check_reg("sra=fff0", 3'd1, 16'hFFF0);
    check_val("sra/zero", bus.zero_flag_o, 0);
    run_instr("sr", enc(OP_SR, 3'd2, 3'd6, 3'd7), 1'b0);
    check_reg("sr=0ff0", 3'd2, 16'h0FF0);
    run_instr("sl", enc(OP_SL, 3'd3, 3'd7, 3'd7), 1'b0);
    check_reg("sl=0040", 3'd3, 16'h0040);

    run_instr("ill_0111", enc(4'b0111, 3'd1, 3'd2, 3'd3), 1'b1);
    check_reg("ill/r1", 3'd1, 16'hFFF0);
    run_instr("ill_1111", enc(4'b1111, 3'd2, 3'd1, 3'd3), 1'b1);
    check_reg("ill/r2", 3'd2, 16'h0FF0);
    run_instr("nop", enc(OP_NOP, 3'd3, 3'd1, 3'd2), 1'b0);
    check_reg("nop/r3", 3'd3, 16'h0040);
    run_instr("add_r0", enc(OP_ADD, 3'd0, 3'd1, 3'd2), 1'b0);
    check_val("add_r0/exec_op", exec_op, 32'(OP_ADD));
    check_reg("r0=0", 3'd0, 16'h0000);

    // valid held high over a queue of four dependent instructions
    q[0] = ldi(3'd1, 9'd1);
    q[1] = ldi(3'd2, 9'd2);
    q[2] = enc(OP_ADD, 3'd3, 3'd1, 3'd2);
    q[3] = enc(OP_XOR, 3'd4, 3'd3, 3'd1);
    idx = 0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done_o) n_done++;
      if (idx < 4) begin
        bus.instr_i       = q[idx];
        bus.instr_valid_i = 1'b1;
        if (bus.instr_ready_o) begin
          acc[idx] = c;
          idx++;
        end
      end else begin
        bus.instr_valid_i = 1'b0;
      end
    end
    bus.instr_valid_i = 1'b0;
    check_val("stream/accepts", idx, 4);
    for (int i = 0; i < 3; i++) check_val($sformatf("stream/gap%0d", i), acc[i+1] - acc[i], 4);
    check_val("stream/dones", n_done, 4);
    check_reg("stream/r3", 3'd3, 16'h0003);
    check_reg("stream/r4", 3'd4, 16'h0002);

    // reset while ADD r3 sits in EXEC
    run_instr("pre_ldi1", ldi(3'd1, 9'd5), 1'b0);
    run_instr("pre_ldi2", ldi(3'd2, 9'd3), 1'b0);
    run_instr("pre_sub", enc(OP_SUB, 3'd4, 3'd1, 3'd1), 1'b0);
    check_val("pre/zero", bus.zero_flag_o, 1);
    @(negedge clk);
    bus.instr_i       = enc(OP_ADD, 3'd3, 3'd1, 3'd2);
    bus.instr_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid_i = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid/exec_op", bus.alu_opcode_o, OP_ADD);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid/ready", bus.instr_ready_o, 1);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done_o) n_done++;
    end
    rst_n = 1'b1;
    check_reg("mid/r1", 3'd1, 16'h0000);
    check_reg("mid/r2", 3'd2, 16'h0000);
    check_reg("mid/r3", 3'd3, 16'h0000);
    check_reg("mid/r4", 3'd4, 16'h0000);
    check_val("mid/zero", bus.zero_flag_o, 0);
    @(posedge clk);
    #1;
    check_val("mid/ready_after", bus.instr_ready_o, 1);
    repeat (4) begin
      @(negedge clk);
      if (bus.done_o) n_done++;
    end
    check_val("mid/no_done", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
